// File: rtl/modal_reg_sequencer.sv
// modal_reg_sequencer: turns valid/ready commands into timed mode/Ser/D drive for an 8-bit modal shift/load register
module modal_reg_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
  output logic [2:0]       mode,
  output logic             Ser,
  output logic [WIDTH-1:0] D,
  output logic             busy,
  output logic             done
);
  localparam logic [1:0] IDLE = 2'd0, SINGLE = 2'd1, SHIFT = 2'd2, FIN = 2'd3;
  localparam logic [2:0] OP_SHR = 3'b001, OP_SHL = 3'b010, OP_LOAD = 3'b011, OP_AND = 3'b101, OP_OR = 3'b110;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt, eff_len;
  logic [WIDTH-1:0] sbuf, aligned;
  logic             accept;
  assign cmd_ready = (state == IDLE) && !Rst;
  // left shifts go MSB-first, so park bit N-1 at the top of the buffer
  always_comb begin
    eff_len = (cmd_len == '0 || cmd_len > FULL) ? FULL : cmd_len;
    aligned = cmd_data << (FULL - eff_len);
    accept  = cmd_valid && cmd_ready;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      mode  <= '0;
      Ser   <= 1'b0;
      D     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      sbuf  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          busy <= 1'b1;
          if (cmd_op == OP_LOAD || cmd_op == OP_AND || cmd_op == OP_OR) begin
            state <= SINGLE;
            mode  <= cmd_op;
            D     <= cmd_data;
          end else if (cmd_op == OP_SHR || cmd_op == OP_SHL) begin
            state <= SHIFT;
            mode  <= cmd_op;
            cnt   <= eff_len;
            Ser   <= cmd_op == OP_SHR ? cmd_data[0] : aligned[WIDTH-1];
            sbuf  <= cmd_op == OP_SHR ? cmd_data >> 1 : aligned << 1;
          end else begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        SINGLE: begin
          state <= FIN;
          mode  <= '0;
          D     <= '0;
          done  <= 1'b1;
        end
        SHIFT: if (cnt == CNT_W'(1)) begin
          state <= FIN;
          mode  <= '0;
          Ser   <= 1'b0;
          cnt   <= '0;
          sbuf  <= '0;
          done  <= 1'b1;
        end else begin
          cnt  <= cnt - CNT_W'(1);
          Ser  <= mode == OP_SHR ? sbuf[0] : sbuf[WIDTH-1];
          sbuf <= mode == OP_SHR ? sbuf >> 1 : sbuf << 1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_modal_reg_sequencer.sv
// tb_modal_reg_sequencer: drives commands, models the downstream modal register, scoreboards result and latency
module tb_modal_reg_sequencer;
  logic       Clk, Rst, cmd_valid, cmd_ready, Ser, busy, done;
  logic [2:0] cmd_op, mode;
  logic [7:0] cmd_data, D, q;
  logic [3:0] cmd_len;
  int pass_cnt = 0, total = 0;
  logic [7:0] exp_q[$];
  int         exp_lat[$];

  modal_reg_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .mode(mode), .Ser(Ser), .D(D), .busy(busy), .done(done)
  );

  initial Clk = 0;
  always #5 Clk = ~Clk;

  // independent model of the downstream modal register
  always @(posedge Clk) begin
    if (Rst) q <= 8'h00;
    else case (mode)
      3'b001: q <= {Ser, q[7:1]};
      3'b010: q <= {q[6:0], Ser};
      3'b011: q <= D;
      3'b101: q <= q & D;
      3'b110: q <= q | D;
      default: q <= q;
    endcase
  end

  task automatic send(input logic [2:0] op, input logic [7:0] data, input logic [3:0] len,
                      input logic [7:0] eq, input int el);
    int w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin @(posedge Clk); #1; w++; end
    cmd_op = op; cmd_data = data; cmd_len = len; cmd_valid = 1;
    @(posedge Clk); #1;
    cmd_valid = 0; cmd_op = 3'($urandom); cmd_data = 8'($urandom); cmd_len = 4'($urandom);
    exp_q.push_back(eq);
    exp_lat.push_back(el);
  endtask

  task automatic run(output int lat, output logic [7:0] seq, output int nsh);
    lat = 1; seq = 0; nsh = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (mode == 3'b001 || mode == 3'b010) begin seq = {seq[6:0], Ser}; nsh++; end
      @(posedge Clk); #1; lat++;
    end
  endtask

  task automatic test_reset;
    Rst = 1; cmd_valid = 0; cmd_op = 0; cmd_data = 0; cmd_len = 0;
    repeat (2) @(posedge Clk);
    #1;
    total++; if ({mode, Ser, D, busy, done} !== 13'h0) $display("FAIL reset_outputs got %h want 0", {mode, Ser, D, busy, done}); else pass_cnt++;
    total++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", cmd_ready); else pass_cnt++;
    Rst = 0;
    @(posedge Clk); #1;
    total++; if (cmd_ready !== 1'b1) $display("FAIL ready_after_reset got %b want 1", cmd_ready); else pass_cnt++;
  endtask

  task automatic test_load;
    int lat, nsh; logic [7:0] seq;
    send(3'b011, 8'hA5, 4'd0, 8'hA5, 2);
    total++; if ({mode, D, busy, cmd_ready} !== {3'b011, 8'hA5, 2'b10}) $display("FAIL load_drive got %h want %h", {mode, D, busy, cmd_ready}, {3'b011, 8'hA5, 2'b10}); else pass_cnt++;
    run(lat, seq, nsh);
    total++; if (lat !== exp_lat.pop_front()) $display("FAIL load_latency got %0d want 2", lat); else pass_cnt++;
    total++; if (q !== exp_q.pop_front()) $display("FAIL load_q got %h want a5", q); else pass_cnt++;
  endtask

  task automatic test_shift_right;
    int lat, nsh; logic [7:0] seq;
    send(3'b001, 8'h3C, 4'd0, 8'h3C, 9);
    total++; if ({mode, D} !== {3'b001, 8'h00}) $display("FAIL shr_drive got %h want 100", {mode, D}); else pass_cnt++;
    run(lat, seq, nsh);
    total++; if (seq !== 8'h3C || nsh !== 8) $display("FAIL shr_ser_seq got %h/%0d want 3c/8", seq, nsh); else pass_cnt++;
    total++; if (lat !== exp_lat.pop_front()) $display("FAIL shr_latency got %0d want 9", lat); else pass_cnt++;
    total++; if (q !== exp_q.pop_front()) $display("FAIL shr_q got %h want 3c", q); else pass_cnt++;
    total++; if ({mode, Ser, D, busy} !== {3'b000, 1'b0, 8'h00, 1'b1}) $display("FAIL fin_outputs got %h want 1", {mode, Ser, D, busy}); else pass_cnt++;
  endtask

  task automatic test_shift_left;
    int lat, nsh; logic [7:0] seq;
    send(3'b011, 8'hFF, 4'd0, 8'hFF, 2);
    run(lat, seq, nsh);
    total++; if (q !== exp_q.pop_front() || lat !== exp_lat.pop_front()) $display("FAIL preload_ff got %h/%0d want ff/2", q, lat); else pass_cnt++;
    send(3'b010, 8'h05, 4'd3, 8'hFD, 4);
    run(lat, seq, nsh);
    total++; if (seq !== 8'h05 || nsh !== 3) $display("FAIL shl_ser_seq got %h/%0d want 05/3", seq, nsh); else pass_cnt++;
    total++; if (lat !== exp_lat.pop_front()) $display("FAIL shl_latency got %0d want 4", lat); else pass_cnt++;
    total++; if (q !== exp_q.pop_front()) $display("FAIL shl_q got %h want fd", q); else pass_cnt++;
  endtask

  task automatic test_len_clamp;
    int lat, nsh; logic [7:0] seq;
    send(3'b001, 8'h81, 4'd12, 8'h81, 9);
    run(lat, seq, nsh);
    total++; if (nsh !== 8 || lat !== exp_lat.pop_front()) $display("FAIL len_clamp got %0d shifts lat %0d want 8/9", nsh, lat); else pass_cnt++;
    total++; if (q !== exp_q.pop_front()) $display("FAIL len_clamp_q got %h want 81", q); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat, nsh; logic [7:0] seq;
    logic [2:0] ops[4] = '{3'b011, 3'b101, 3'b110, 3'b111};
    logic [7:0] dat[4] = '{8'hF0, 8'h3C, 8'h0F, 8'hAA};
    logic [7:0] res[4] = '{8'hF0, 8'h30, 8'h3F, 8'h3F};
    int         lats[4] = '{2, 2, 2, 1};
    for (int i = 0; i < 4; i++) begin
      send(ops[i], dat[i], 4'd5, res[i], lats[i]);
      run(lat, seq, nsh);
      total++; if (lat !== exp_lat.pop_front()) $display("FAIL b2b_latency[%0d] got %0d want %0d", i, lat, lats[i]); else pass_cnt++;
      total++; if (q !== exp_q.pop_front()) $display("FAIL b2b_q[%0d] got %h want %h", i, q, res[i]); else pass_cnt++;
      total++; if (cmd_ready !== 1'b0) $display("FAIL b2b_ready_in_fin[%0d] got %b want 0", i, cmd_ready); else pass_cnt++;
      @(posedge Clk); #1;
      total++; if (cmd_ready !== 1'b1 || done !== 1'b0) $display("FAIL b2b_ready_after[%0d] got %b%b want 10", i, cmd_ready, done); else pass_cnt++;
    end
  endtask

  task automatic test_busy_ignore;
    int lat = 1;
    send(3'b011, 8'h55, 4'd0, 8'h55, 2);
    cmd_valid = 1;
    while (done !== 1'b1 && lat < 40) begin
      cmd_op = 3'($urandom); cmd_data = 8'($urandom);
      @(posedge Clk); #1; lat++;
    end
    cmd_valid = 0;
    total++; if (lat !== exp_lat.pop_front() || q !== exp_q.pop_front()) $display("FAIL busy_ignore got %h/%0d want 55/2", q, lat); else pass_cnt++;
    @(posedge Clk); #1;
    total++; if (busy !== 1'b0 || q !== 8'h55) $display("FAIL busy_ignore_after got %b/%h want 0/55", busy, q); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    bit saw_done = 0;
    send(3'b001, 8'hFF, 4'd0, 8'hFF, 9);
    void'(exp_q.pop_front());
    void'(exp_lat.pop_front());
    repeat (3) begin @(posedge Clk); #1; end
    Rst = 1;
    @(posedge Clk); #1;
    total++; if ({mode, Ser, busy, done, cmd_ready} !== 7'h0) $display("FAIL midreset_outputs got %h want 0", {mode, Ser, busy, done, cmd_ready}); else pass_cnt++;
    Rst = 0;
    repeat (12) begin @(posedge Clk); #1; if (done === 1'b1) saw_done = 1; end
    total++; if (saw_done) $display("FAIL midreset_done got 1 want 0"); else pass_cnt++;
    total++; if (cmd_ready !== 1'b1 || mode !== 3'b000) $display("FAIL midreset_recover got %b/%b want 1/000", cmd_ready, mode); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_load;
    test_shift_right;
    test_shift_left;
    test_len_clamp;
    test_back_to_back;
    test_busy_ignore;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
